// File: rtl/ulpb_rx_msg_buffer_pkg.sv
// Shared constants, FSM encoding and helpers for the ULPB RX message buffer.
// Optional statistics counters are enabled by ULPB_RX_BUF_STATS_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package ulpb_rx_msg_buffer_pkg;

   localparam int ULPB_ADDR_W = `ADDR_WIDTH;
   localparam int ULPB_DATA_W = `DATA_WIDTH;
   localparam int LAST_W      = 1;
   localparam int CNT_W       = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ_HS  = 2'd1,
      ST_FAIL_HS = 2'd2
   } rx_state_t;

   // One FIFO entry packs {addr, data, last}.
   function automatic int entry_width(input int aw, input int dw);
      return aw + dw + LAST_W;
   endfunction

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/ulpb_rx_msg_buffer_sync.sv
// Reset-to-zero flop chain bringing an asynchronous level into the clk domain.
module ulpb_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain_reg;
   logic [STAGES-1:0] chain_next;

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            assign chain_next[gi] = d;
         end else begin : g_rest
            assign chain_next[gi] = chain_reg[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         chain_reg <= '0;
      end else begin
         chain_reg <= chain_next;
      end
   end

   assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/ulpb_rx_msg_buffer.sv
// Message-framed RX FIFO: acks node words, exposes only committed messages.
// Define ULPB_RX_BUF_STATS_EN to add msg_cnt/fail_cnt/drop_cnt outputs.
module ulpb_rx_msg_buffer
   import ulpb_rx_msg_buffer_pkg::*;
#(
   parameter int ADDR_WIDTH  = ULPB_ADDR_W,
   parameter int DATA_WIDTH  = ULPB_DATA_W,
   parameter int DEPTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [ADDR_WIDTH-1:0] rx_addr,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  rx_pend,
   input  logic                  rx_req,
   input  logic                  rx_fail,
   output logic                  rx_ack,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_last,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  overflow,
   input  logic                  overflow_clr
`ifdef ULPB_RX_BUF_STATS_EN
   ,
   output logic [CNT_W-1:0]      msg_cnt,
   output logic [CNT_W-1:0]      fail_cnt,
   output logic [CNT_W-1:0]      drop_cnt
`endif
);

   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;
   localparam int EW = entry_width(ADDR_WIDTH, DATA_WIDTH);
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   logic [EW-1:0] mem [DEPTH];

   rx_state_t state_reg, state_next;
   logic [PW-1:0] wr_reg, wr_next;
   logic [PW-1:0] cm_reg, cm_next;
   logic [PW-1:0] rd_reg, rd_next;
   logic discard_reg, discard_next;
   logic rx_ack_reg, rx_ack_next;
   logic overflow_reg, overflow_next;

   logic req_s, fail_s;
   logic [PW-1:0] used, uncommitted;
   logic full, unc_full, rd_fire;
   logic mem_we, commit_ev, ovf_set;

   ulpb_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_req (
      .clk    (clk),
      .resetn (resetn),
      .d      (rx_req),
      .q      (req_s)
   );

   ulpb_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_fail (
      .clk    (clk),
      .resetn (resetn),
      .d      (rx_fail),
      .q      (fail_s)
   );

   assign used        = wr_reg - rd_reg;
   assign uncommitted = wr_reg - cm_reg;
   assign full        = (used == DEPTH_P);
   // A full buffer holding only the current message can never drain: it must be dropped.
   assign unc_full    = (uncommitted == DEPTH_P);

   assign out_valid = (rd_reg != cm_reg);
   assign {out_addr, out_data, out_last} = mem[rd_reg[IW-1:0]];
   assign rd_fire   = out_valid & out_ready;
   assign rd_next   = rd_fire ? rd_reg + PTR_ONE : rd_reg;

   assign rx_ack   = rx_ack_reg;
   assign overflow = overflow_reg;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (fail_s) begin
               state_next = ST_FAIL_HS;
            end else if (req_s && (discard_reg || !full || unc_full)) begin
               state_next = ST_REQ_HS;
            end
         end
         ST_REQ_HS: begin
            if (!req_s) state_next = ST_IDLE;
         end
         ST_FAIL_HS: begin
            if (!fail_s) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      wr_next      = wr_reg;
      cm_next      = cm_reg;
      discard_next = discard_reg;
      mem_we       = 1'b0;
      commit_ev    = 1'b0;
      ovf_set      = 1'b0;
      // rx_ack is high exactly while a handshake state is being held.
      rx_ack_next  = (state_next != ST_IDLE);
      if (state_reg == ST_IDLE) begin
         if (fail_s) begin
            wr_next      = cm_reg;
            discard_next = 1'b0;
         end else if (req_s) begin
            if (discard_reg) begin
               if (!rx_pend) discard_next = 1'b0;
            end else if (!full) begin
               mem_we  = 1'b1;
               wr_next = wr_reg + PTR_ONE;
               if (!rx_pend) begin
                  cm_next   = wr_reg + PTR_ONE;
                  commit_ev = 1'b1;
               end
            end else if (unc_full) begin
               ovf_set = 1'b1;
               wr_next = cm_reg;
               if (rx_pend) discard_next = 1'b1;
            end
         end
      end
      overflow_next = ovf_set | (overflow_reg & ~overflow_clr);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_reg       <= '0;
         cm_reg       <= '0;
         rd_reg       <= '0;
         discard_reg  <= 1'b0;
         rx_ack_reg   <= 1'b0;
         overflow_reg <= 1'b0;
      end else begin
         wr_reg       <= wr_next;
         cm_reg       <= cm_next;
         rd_reg       <= rd_next;
         discard_reg  <= discard_next;
         rx_ack_reg   <= rx_ack_next;
         overflow_reg <= overflow_next;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wr_reg[IW-1:0]] <= {rx_addr, rx_data, ~rx_pend};
      end
   end

`ifdef ULPB_RX_BUF_STATS_EN
   logic [2:0] stat_ev;
   assign stat_ev = {ovf_set, (state_reg == ST_IDLE) && fail_s, commit_ev};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_stat
         logic [CNT_W-1:0] cnt_reg;
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               cnt_reg <= '0;
            end else if (stat_ev[gi]) begin
               cnt_reg <= sat_inc(cnt_reg);
            end
         end
      end
   endgenerate

   assign msg_cnt  = g_stat[0].cnt_reg;
   assign fail_cnt = g_stat[1].cnt_reg;
   assign drop_cnt = g_stat[2].cnt_reg;
`endif

endmodule

// File: tb/tb_ulpb_rx_msg_buffer.sv
// Directed scoreboard bench for ulpb_rx_msg_buffer (DEPTH=4, SYNC_STAGES=2).
module tb_ulpb_rx_msg_buffer;

   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int SYNC  = 2;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          last;
   } ent_t;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [AW-1:0] rx_addr = '0;
   logic [DW-1:0] rx_data = '0;
   logic          rx_pend = 1'b0;
   logic          rx_req = 1'b0;
   logic          rx_fail = 1'b0;
   logic          rx_ack;
   logic [AW-1:0] out_addr;
   logic [DW-1:0] out_data;
   logic          out_last;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          overflow;
   logic          overflow_clr = 1'b0;

   ent_t pend_q[$];
   ent_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   ulpb_rx_msg_buffer #(
      .ADDR_WIDTH  (AW),
      .DATA_WIDTH  (DW),
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SYNC)
   ) dut (
      .clk          (clk),
      .resetn       (resetn),
      .rx_addr      (rx_addr),
      .rx_data      (rx_data),
      .rx_pend      (rx_pend),
      .rx_req       (rx_req),
      .rx_fail      (rx_fail),
      .rx_ack       (rx_ack),
      .out_addr     (out_addr),
      .out_data     (out_data),
      .out_last     (out_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .overflow     (overflow),
      .overflow_clr (overflow_clr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for rx_ack to reach val; returns cycles elapsed.
   task automatic wait_ack(input logic val, input string tag, output int cyc);
      cyc = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         if (rx_ack === val) break;
      end
      chk(tag, 64'(rx_ack), 64'(val));
   endtask

   task automatic send_word(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic p);
      int cyc;
      @(negedge clk);
      rx_addr = a;
      rx_data = d;
      rx_pend = p;
      rx_req  = 1'b1;
      wait_ack(1'b1, "ack_rise", cyc);
      rx_req = 1'b0;
      wait_ack(1'b0, "ack_fall", cyc);
      pend_q.push_back('{addr: a, data: d, last: ~p});
      $display("rx word addr=%0h data=%0h pend=%0b ack_cycles=%0d", a, d, p, cyc);
   endtask

   task automatic commit_msg();
      while (pend_q.size() > 0) exp_q.push_back(pend_q.pop_front());
   endtask

   task automatic pop_one(input string tag);
      ent_t e;
      @(negedge clk);
      for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      if (exp_q.size() == 0) begin
         $display("FAIL %s scoreboard empty", tag);
         $fatal(1, "scoreboard underflow");
      end
      e = exp_q.pop_front();
      chk({tag, "_addr"}, 64'(out_addr), 64'(e.addr));
      chk({tag, "_data"}, 64'(out_data), 64'(e.data));
      chk({tag, "_last"}, 64'(out_last), 64'(e.last));
      $display("out word addr=%0h data=%0h last=%0b", out_addr, out_data, out_last);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   initial begin
      int cyc;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack", 64'(rx_ack), 64'd0);
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      @(negedge clk);
      resetn = 1'b1;

      // Single word: latency of the ack and immediate visibility after commit
      @(negedge clk);
      rx_addr = 8'hab;
      rx_data = 32'hDEADBEEF;
      rx_pend = 1'b0;
      rx_req  = 1'b1;
      wait_ack(1'b1, "single_ack", cyc);
      chk("ack_latency", 64'(cyc), 64'(SYNC + 1));
      chk("single_valid", 64'(out_valid), 64'd1);
      rx_req = 1'b0;
      wait_ack(1'b0, "single_ack_fall", cyc);
      pend_q.push_back('{addr: 8'hab, data: 32'hDEADBEEF, last: 1'b1});
      commit_msg();
      $display("rx word addr=ab data=deadbeef pend=0");
      pop_one("single");

      // Three-word message held back until its last word
      send_word(8'h10, 32'd1, 1'b1);
      chk("msg3_w1_valid", 64'(out_valid), 64'd0);
      send_word(8'h11, 32'd2, 1'b1);
      chk("msg3_w2_valid", 64'(out_valid), 64'd0);
      send_word(8'h12, 32'd3, 1'b0);
      chk("msg3_w3_valid", 64'(out_valid), 64'd1);
      commit_msg();
      for (int i = 0; i < 3; i++) pop_one("msg3");

      // RX_FAIL mid-message rolls the partial message back
      send_word(8'h20, 32'hA1, 1'b1);
      send_word(8'h21, 32'hA2, 1'b1);
      @(negedge clk);
      rx_fail = 1'b1;
      wait_ack(1'b1, "fail_ack_rise", cyc);
      rx_fail = 1'b0;
      wait_ack(1'b0, "fail_ack_fall", cyc);
      pend_q.delete();
      $display("rx fail handshake done");
      chk("fail_valid", 64'(out_valid), 64'd0);
      send_word(8'h30, 32'h55, 1'b0);
      commit_msg();
      pop_one("after_fail");

      // Six-word message overflows a four-entry buffer
      for (int i = 0; i < 6; i++) begin
         send_word(8'h40 + 8'(i), 32'h100 + 32'(i), (i < 5) ? 1'b1 : 1'b0);
         if (i == 3) chk("ovf_before", 64'(overflow), 64'd0);
         if (i == 4) chk("ovf_after5", 64'(overflow), 64'd1);
      end
      pend_q.delete();
      chk("ovf_valid", 64'(out_valid), 64'd0);
      send_word(8'h50, 32'hC0FFEE, 1'b0);
      commit_msg();
      pop_one("after_ovf");
      chk("ovf_sticky", 64'(overflow), 64'd1);
      @(negedge clk);
      overflow_clr = 1'b1;
      @(negedge clk);
      overflow_clr = 1'b0;
      chk("ovf_clr", 64'(overflow), 64'd0);

      // Backpressure: a full committed buffer withholds rx_ack
      send_word(8'h60, 32'h61, 1'b1);
      send_word(8'h60, 32'h62, 1'b0);
      commit_msg();
      send_word(8'h70, 32'h71, 1'b1);
      send_word(8'h70, 32'h72, 1'b0);
      commit_msg();
      @(negedge clk);
      rx_addr = 8'h80;
      rx_data = 32'h81;
      rx_pend = 1'b0;
      rx_req  = 1'b1;
      repeat (10) @(negedge clk);
      chk("bp_stall_ack", 64'(rx_ack), 64'd0);
      pop_one("bp_pulse");
      wait_ack(1'b1, "bp_ack_rise", cyc);
      rx_req = 1'b0;
      wait_ack(1'b0, "bp_ack_fall", cyc);
      pend_q.push_back('{addr: 8'h80, data: 32'h81, last: 1'b1});
      commit_msg();
      $display("rx word addr=80 data=81 pend=0 (after stall)");
      for (int i = 0; i < 4; i++) pop_one("bp_drain");

      // Reset while holding REQ_HS with a committed word pending
      send_word(8'h90, 32'h91, 1'b0);
      commit_msg();
      @(negedge clk);
      rx_addr = 8'h92;
      rx_data = 32'h93;
      rx_pend = 1'b1;
      rx_req  = 1'b1;
      wait_ack(1'b1, "rst_mid_ack", cyc);
      @(negedge clk);
      resetn = 1'b0;
      #1;
      chk("rst_mid_ack_low", 64'(rx_ack), 64'd0);
      chk("rst_mid_valid", 64'(out_valid), 64'd0);
      rx_req = 1'b0;
      pend_q.delete();
      exp_q.delete();
      $display("reset asserted mid-handshake");
      @(negedge clk);
      resetn = 1'b1;
      send_word(8'hA0, 32'hB1, 1'b1);
      send_word(8'hA1, 32'hB2, 1'b0);
      commit_msg();
      for (int i = 0; i < 2; i++) pop_one("post_rst");
      chk("final_empty", 64'(out_valid), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ulpb_rx_msg_buffer.md
Name: ulpb_rx_msg_buffer

Overview:
- Consumer stage on the RX side of a ulpb_node32 (or ulpb_ctrl_wrapper) node.
- Completes the node's four-phase RX_REQ/RX_ACK and RX_FAIL/RX_ACK handshakes and stores received words in a message-framed FIFO.
- Presents only complete (committed) messages to the local layer on a valid/ready stream.
- Partial messages aborted by RX_FAIL or overflow are rolled back and never reach the output.

Parameters:
- ADDR_WIDTH, 8, width of rx_addr/out_addr (matches `ADDR_WIDTH).
- DATA_WIDTH, 32, width of rx_data/out_data (matches `DATA_WIDTH).
- DEPTH, 8, FIFO entries; power of two, ≥2.
- SYNC_STAGES, 2, flops synchronising rx_req/rx_fail into clk; ≥1.

Ports:
- clk  in  1  local clock
- resetn  in  1  reset; asynchronous, active-low
- rx_addr  in  ADDR_WIDTH  node RX_ADDR; stable while rx_req high
- rx_data  in  DATA_WIDTH  node RX_DATA; stable while rx_req high
- rx_pend  in  1  node RX_PEND; 1 = more words follow in this message
- rx_req  in  1  node RX_REQ
- rx_fail  in  1  node RX_FAIL
- rx_ack  out  1  to node RX_ACK; registered
- out_addr  out  ADDR_WIDTH  address of head word
- out_data  out  DATA_WIDTH  head word
- out_last  out  1  head word is the last word of its message
- out_valid  out  1  head word is committed
- out_ready  in  1  consumer accepts the head word
- overflow  out  1  sticky: a message was dropped because it exceeded DEPTH
- overflow_clr  in  1  synchronous clear of overflow

Behaviour:
- Reset values: rx_ack=0, overflow=0, all pointers=0, discard=0, state IDLE. Therefore out_valid=0.
- rx_req and rx_fail pass through SYNC_STAGES flops, giving req_s and fail_s. rx_addr/rx_data/rx_pend are sampled only when req_s=1.
- Entry format: {addr, data, last}, with last = ~rx_pend.
- Pointers wr, cm (commit) and rd are each log2(DEPTH)+1 bits wide.
  - used = wr-rd.
  - full when used==DEPTH.
  - uncommitted = wr-cm.
- out_valid = (rd!=cm). out_* are driven combinationally from mem[rd]. rd increments on out_valid&out_ready.
- FSM IDLE:
  - fail_s=1 has priority over req_s. Action: wr<=cm (rollback), discard<=0, rx_ack<=1, go to FAIL_HS.
  - Else req_s=1 and discard=1: drop the word, rx_ack<=1, go to REQ_HS. If rx_pend=0, clear discard.
  - Else req_s=1 and not full: write mem[wr], wr<=wr+1. If rx_pend=0, cm<=wr+1 (commit). Then rx_ack<=1, go to REQ_HS.
  - Else req_s=1, full, and uncommitted<DEPTH: stall in IDLE with rx_ack=0 until the reader frees space.
  - Else req_s=1, full, and uncommitted==DEPTH: overflow<=1, wr<=cm. If rx_pend=1, discard<=1. Drop the word, rx_ack<=1, go to REQ_HS.
- FSM REQ_HS: wait for req_s=0, then rx_ack<=0 and return to IDLE.
- FSM FAIL_HS: wait for fail_s=0, then rx_ack<=0 and return to IDLE.
- Latency: rx_ack rises SYNC_STAGES+1 clk cycles after rx_req rises, when space is available. A committed word shows out_valid the cycle after the commit write.
- Simultaneous read and write: both are allowed in the same cycle. Fullness is evaluated on pre-update pointers.
- Rollback never moves rd or cm; committed messages are unaffected.
- overflow_clr and a new overflow in the same cycle: overflow stays 1.
- Reset mid-handshake: rx_ack drops immediately and any partial message is lost. The node recovers through its own reset.

Optional Feature:
- Macro ULPB_RX_BUF_STATS_EN.
- When defined, adds three outputs:
  - msg_cnt[15:0]: increments per committed message.
  - fail_cnt[15:0]: increments on each entry to FAIL_HS.
  - drop_cnt[15:0]: increments on each overflow drop.
  - All three saturate at 16'hFFFF and reset to 0.
- When not defined, these ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package: entry field widths, FSM state encodings (IDLE=2'd0, REQ_HS=2'd1, FAIL_HS=2'd2), the counter width constant, and `ADDR_WIDTH/`DATA_WIDTH from ulpb_def.
- One sub-module: ulpb_sync_bit (SYNC_STAGES-deep flop chain with reset to 0). It is instantiated for rx_req and rx_fail.

Test Plan:
- Single word: addr 8'hab, data 32'hDEADBEEF, pend=0 → rx_ack rises SYNC_STAGES+1 cycles after rx_req. Then out_valid=1, out_last=1, out_data=32'hDEADBEEF.
- Three-word message (pend 1,1,0), data 1,2,3, out_ready=0 → out_valid stays 0 until the third word is acked. Then words 1,2,3 drain in order with last only on 3.
- Fail mid-message: two words with pend=1, then rx_fail → rx_ack handshake completes and out_valid never rises. A following single-word message 32'h55 is the first word output.
- Overflow, DEPTH=4: 6-word message → overflow=1 after the 5th word and all words are acked. Nothing is output. A next 1-word message is received normally. overflow_clr clears the flag.
- Backpressure, DEPTH=4: two committed 2-word messages fill the buffer with out_ready=0; then a new rx_req → rx_ack is withheld. Pulsing out_ready for one word → rx_ack rises and the new word is stored.
- Reset with rx_req high in REQ_HS → rx_ack=0 and out_valid=0 immediately. After release, a fresh message completes normally.
